issue_controller: RTL
=====================

Name: issue_controller

Overview:
- Sits between the decoder and the execute stage and decides, each cycle, whether the decoded instruction may issue.
- Keeps a scoreboard of pending writes to the scalar (S) and predicate (P) register banks and stalls on RAW and WAW hazards.
- Bounds the number of in-flight writes, holds issue while a control-flow instruction resolves, and sequences the halt drain.

Parameters:
- NUM_S_REGS, 32, scalar bank entries; address width `REG_SEL.
- NUM_P_REGS, 8, predicate bank entries; only the low 3 address bits are used.
- MAX_INFLIGHT, 4, maximum number of issued but not yet written-back destination writes (range 1..15).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- dec_valid  in  1  decoder presents an instruction.
- a_from_regbank, a_regbank_sel, a_regbank_addr  in  1,1,`REG_SEL  operand A source.
- b_from_regbank, b_regbank_sel, b_regbank_addr  in  1,1,`REG_SEL  operand B source.
- z_write, z_regbank_sel, z_regbank_addr  in  1,1,`REG_SEL  destination write enable and address.
- is_ctrl  in  1  instruction is BR, CALL or RET.
- is_halt  in  1  instruction is HALT.
- wb_valid, wb_regbank_sel, wb_regbank_addr  in  1,1,`REG_SEL  writeback completes; clears busy.
- br_resolve_valid, br_taken  in  1,1  control-flow outcome from execute.
- dec_ready  out  1  instruction accepted this cycle.
- issue_valid  out  1  equals dec_valid && dec_ready.
- flush  out  1  one-cycle pulse that squashes fetch/decode.
- halted  out  1  core halted.
- inflight  out  4  outstanding write count.

Behaviour:
- Reset values: state=RUN; both busy vectors 0; inflight=0; dec_ready=0 while rst is high; flush=0; halted=0. Reset asserted mid-operation discards all state immediately.
- Bank select encoding: `S_REGS=0, `P_REGS=1. Scalar R0 is never marked busy. All predicate entries are tracked.
- Effective busy: busy bit AND NOT (wb_valid with matching sel/addr). Writeback clears are visible to the hazard check in the same cycle.
- hazard = (a_from_regbank && effbusy(A)) || (b_from_regbank && effbusy(B)) || (z_write && effbusy(Z)).
- dec_ready = (state==RUN) && !hazard && !(z_write && inflight_after_wb == MAX_INFLIGHT).
  - inflight_after_wb = inflight - wb_valid.
- On issue with z_write and a non-R0 destination: set the busy bit and increment inflight.
- Same-cycle wb_valid on the same register as an issuing write: the set wins, so the bit stays busy.
- Each wb_valid decrements inflight. A simultaneous issue-write plus wb_valid leaves inflight unchanged.
- wb_valid on a non-busy register, or with inflight=0, is a protocol error. The bit stays 0 and inflight saturates at 0.
- States:
  - RUN: issue of is_ctrl -> WAIT_BR; issue of is_halt -> DRAIN; otherwise stay.
  - WAIT_BR: dec_ready=0. On br_resolve_valid: flush = br_taken (combinational, same cycle), next state RUN.
  - DRAIN: dec_ready=0; wait for writebacks. When inflight==0 (after this cycle's decrement) -> HALTED.
  - HALTED: halted=1, dec_ready=0. Exit only by rst.
- br_resolve_valid outside WAIT_BR is ignored; flush stays 0.
- Latency: issue decision is combinational on the current inputs. Scoreboard and FSM update on the next edge.

Test Plan:
- Reset then ADD (z=S5, A=S1, B=S2, no busy) -> issue_valid=1; next cycle busy_S[5]=1, inflight=1.
- Next instruction reads S5 -> dec_ready=0 until wb_valid S5. Issue occurs in the wb_valid cycle (same-cycle bypass).
- Issue 4 writes to S1..S4 with no writeback, then a 5th write to S6 -> stalled (inflight=4). Pulse wb_valid S1 -> S6 issues that cycle and inflight stays 4.
- BR issued -> dec_ready=0 for 3 cycles. br_resolve_valid=1, br_taken=1 -> flush=1 for exactly one cycle, then RUN. A not-taken resolve gives flush=0.
- HALT issued with inflight=2 -> DRAIN. Two wb_valid pulses -> halted=1 on the following edge, and dec_ready stays 0 with dec_valid=1.
- Write to R0 -> no busy set, inflight unchanged. Assert rst in WAIT_BR -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/issue_controller.sv
// issue_controller
//   Decides each cycle whether the decoded instruction may issue. Tracks
//   pending writes to the scalar (S) and predicate (P) banks, stalls on
//   RAW/WAW hazards, caps in-flight writes, holds issue while control flow
//   resolves and sequences the halt drain.
//
// Ports
//   clk, rst                       clock, async active-high reset
//   dec_valid                      decoder presents an instruction
//   a_/b_from_regbank,_sel,_addr   operand sources
//   z_write, z_regbank_sel/_addr   destination write
//   is_ctrl, is_halt               BR/CALL/RET, HALT
//   wb_valid, wb_regbank_sel/_addr writeback completes (clears busy)
//   br_resolve_valid, br_taken     control-flow outcome
//   dec_ready, issue_valid         accept / issue this cycle
//   flush                          one-cycle squash on taken branch
//   halted                         core halted
//   inflight                       outstanding write count

`ifndef REG_SEL
`define REG_SEL 5
`endif
`ifndef S_REGS
`define S_REGS 1'b0
`endif
`ifndef P_REGS
`define P_REGS 1'b1
`endif

module issue_controller #(
  parameter int NUM_S_REGS   = 32,
  parameter int NUM_P_REGS   = 8,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dec_valid,
  input  logic                a_from_regbank,
  input  logic                a_regbank_sel,
  input  logic [`REG_SEL-1:0] a_regbank_addr,
  input  logic                b_from_regbank,
  input  logic                b_regbank_sel,
  input  logic [`REG_SEL-1:0] b_regbank_addr,
  input  logic                z_write,
  input  logic                z_regbank_sel,
  input  logic [`REG_SEL-1:0] z_regbank_addr,
  input  logic                is_ctrl,
  input  logic                is_halt,
  input  logic                wb_valid,
  input  logic                wb_regbank_sel,
  input  logic [`REG_SEL-1:0] wb_regbank_addr,
  input  logic                br_resolve_valid,
  input  logic                br_taken,
  output logic                dec_ready,
  output logic                issue_valid,
  output logic                flush,
  output logic                halted,
  output logic [3:0]          inflight
);

  typedef enum logic [1:0] {RUN, WAIT_BR, DRAIN, HALTED} state_e;

  state_e                  state_q, state_d;
  logic [NUM_S_REGS-1:0]   busy_s_q, busy_s_d;
  logic [NUM_P_REGS-1:0]   busy_p_q, busy_p_d;
  logic [3:0]              inflight_q, inflight_d;

  // Busy vectors with this cycle's writeback already removed; used both for
  // the hazard check (same-cycle bypass) and as the base of the next state.
  logic [NUM_S_REGS-1:0]   eff_s;
  logic [NUM_P_REGS-1:0]   eff_p;
  logic                    haz_a, haz_b, haz_z, hazard;
  logic [3:0]              inflight_after_wb;
  logic                    set_busy;

  always_comb begin
    eff_s = busy_s_q;
    eff_p = busy_p_q;
    if (wb_valid) begin
      if (wb_regbank_sel == `P_REGS) eff_p[wb_regbank_addr[2:0]] = 1'b0;
      else                           eff_s[wb_regbank_addr]      = 1'b0;
    end
  end

  always_comb begin
    haz_a  = a_from_regbank && ((a_regbank_sel == `P_REGS) ? eff_p[a_regbank_addr[2:0]]
                                                          : eff_s[a_regbank_addr]);
    haz_b  = b_from_regbank && ((b_regbank_sel == `P_REGS) ? eff_p[b_regbank_addr[2:0]]
                                                          : eff_s[b_regbank_addr]);
    haz_z  = z_write && ((z_regbank_sel == `P_REGS) ? eff_p[z_regbank_addr[2:0]]
                                                    : eff_s[z_regbank_addr]);
    hazard = haz_a || haz_b || haz_z;
    // Spurious writeback at zero saturates instead of wrapping.
    inflight_after_wb = (wb_valid && inflight_q != '0) ? inflight_q - 4'd1 : inflight_q;
  end

  // Scoreboard next state: set on issue wins over a same-cycle clear.
  always_comb begin
    busy_s_d   = eff_s;
    busy_p_d   = eff_p;
    set_busy   = issue_valid && z_write &&
                 !(z_regbank_sel == `S_REGS && z_regbank_addr == '0);
    if (set_busy) begin
      if (z_regbank_sel == `P_REGS) busy_p_d[z_regbank_addr[2:0]] = 1'b1;
      else                          busy_s_d[z_regbank_addr]      = 1'b1;
    end
    inflight_d = inflight_after_wb + {3'b000, set_busy};
  end

  // State and scoreboard registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      busy_s_q   <= '0;
      busy_p_q   <= '0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      busy_s_q   <= busy_s_d;
      busy_p_q   <= busy_p_d;
      inflight_q <= inflight_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (issue_valid && is_ctrl)      state_d = WAIT_BR;
        else if (issue_valid && is_halt) state_d = DRAIN;
      end
      WAIT_BR: if (br_resolve_valid)      state_d = RUN;
      DRAIN:   if (inflight_after_wb == '0) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  // Outputs; dec_ready is gated by rst because the register only clears
  // state, not the combinational accept path.
  always_comb begin
    dec_ready   = !rst && (state_q == RUN) && !hazard &&
                  !(z_write && inflight_after_wb == 4'(MAX_INFLIGHT));
    issue_valid = dec_valid && dec_ready;
    flush       = (state_q == WAIT_BR) && br_resolve_valid && br_taken;
    halted      = (state_q == HALTED);
    inflight    = inflight_q;
  end

endmodule
